// File: rtl/box_downscale_stream_if.sv
// Pixel stream bundle for box_downscale_stream: input stream with start-of-frame,
// output stream with end-of-line/end-of-frame markers.
interface box_downscale_stream_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_eol;
  logic          out_eof;

  modport slave (
    input  in_valid, in_data, in_sof, out_ready,
    output in_ready, out_valid, out_data, out_eol, out_eof
  );

  modport master (
    output in_valid, in_data, in_sof, out_ready,
    input  in_ready, out_valid, out_data, out_eol, out_eof
  );
endinterface

// File: rtl/box_downscale_stream.sv
// Streaming 2^S x 2^S downscaler: box average (MODE=0) or top-left decimation (MODE=1)
// using a horizontal accumulator and a one-entry-per-output-column line buffer.
module box_downscale_stream #(
  parameter int DW    = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int S     = 2,
  parameter int MODE  = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  box_downscale_stream_if.slave bus
);
  localparam int F    = 1 << S;
  localparam int COLS = IMG_W / F;
  localparam int ROWS = IMG_H / F;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int CW   = (XW > S) ? XW - S : 1;
  localparam int RW   = (YW > S) ? YW - S : 1;
  localparam int HW   = DW + S;
  localparam int LW   = DW + 2 * S;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [HW-1:0] hacc;
  logic [LW-1:0] lb [COLS];

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic          eol_q;
  logic          eof_q;

  logic          accept;
  logic [XW-1:0] ex;
  logic [YW-1:0] ey;
  logic [S-1:0]  xb;
  logic [S-1:0]  yb;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_x;
  logic          last_y;
  logic          produce;
  logic [HW-1:0] hsum;
  logic [LW-1:0] lb_sum;
  logic [DW-1:0] result;

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_eol   = eol_q;
  assign bus.out_eof   = eof_q;

  assign accept = bus.in_valid && bus.in_ready;

  // A start-of-frame pixel overrides the counters, which also drops any partial block.
  always_comb begin
    ex      = bus.in_sof ? '0 : x;
    ey      = bus.in_sof ? '0 : y;
    xb      = ex[S-1:0];
    yb      = ey[S-1:0];
    col     = CW'(ex >> S);
    row     = RW'(ey >> S);
    last_x  = (ex == XW'(IMG_W - 1));
    last_y  = (ey == YW'(IMG_H - 1));
    hsum    = (xb == '0) ? HW'(bus.in_data) : hacc + HW'(bus.in_data);
    lb_sum  = (yb == '0) ? LW'(hsum) : lb[col] + LW'(hsum);
    if (MODE == 0) begin
      produce = (xb == '1) && (yb == '1);
      result  = DW'(lb_sum >> (2 * S));
    end else begin
      produce = (xb == '0) && (yb == '0);
      result  = bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      hacc    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      if (accept) begin
        hacc <= hsum;
        x    <= last_x ? '0 : ex + 1'b1;
        if (last_x) begin
          y <= last_y ? '0 : ey + 1'b1;
        end else begin
          y <= ey;
        end
      end
      // Loading a new result takes priority so a transfer and a new result share one edge.
      if (accept && produce) begin
        valid_q <= 1'b1;
        data_q  <= result;
        eol_q   <= (col == CW'(COLS - 1));
        eof_q   <= (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1));
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Line buffer needs no reset: the first line of every block row overwrites its entry.
  always_ff @(posedge clk) begin
    if (accept && (xb == '1)) begin
      lb[col] <= lb_sum;
    end
  end
endmodule

// File: tb/tb_box_downscale_stream.sv
// Scoreboard bench: three downscalers (average S=2, decimate S=2, average S=4) fed one
// shared randomized pixel stream, checked against frame-level block arithmetic.
module tb_box_downscale_stream;
  localparam int W    = 64;
  localparam int H    = 32;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   rdy_pct = 100;
  int   img [H][W];
  exp_t q [3][$];

  box_downscale_stream_if #(.DW(8)) avg_if ();
  box_downscale_stream_if #(.DW(8)) dec_if ();
  box_downscale_stream_if #(.DW(8)) s4_if ();

  box_downscale_stream #(.DW(8), .IMG_W(W), .IMG_H(H), .S(2), .MODE(0))
    u_avg (.clk(clk), .rst_n(rst_n), .bus(avg_if));
  box_downscale_stream #(.DW(8), .IMG_W(W), .IMG_H(H), .S(2), .MODE(1))
    u_dec (.clk(clk), .rst_n(rst_n), .bus(dec_if));
  box_downscale_stream #(.DW(8), .IMG_W(W), .IMG_H(H), .S(4), .MODE(0))
    u_s4 (.clk(clk), .rst_n(rst_n), .bus(s4_if));

  // The side DUTs never stall, so they accept exactly what the average DUT accepts.
  assign dec_if.in_valid  = avg_if.in_valid && avg_if.in_ready;
  assign dec_if.in_data   = avg_if.in_data;
  assign dec_if.in_sof    = avg_if.in_sof;
  assign dec_if.out_ready = 1'b1;
  assign s4_if.in_valid   = avg_if.in_valid && avg_if.in_ready;
  assign s4_if.in_data    = avg_if.in_data;
  assign s4_if.in_sof     = avg_if.in_sof;
  assign s4_if.out_ready  = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pix(input int pat, input int px, input int py);
    case (pat)
      0:       return 200;
      1:       return px & 255;
      2:       return 255;
      3:       return ((py & 15) << 4) | (px & 15);
      default: return int'($urandom_range(255));
    endcase
  endfunction

  // Expected outputs of one DUT for a frame of which only the first n_acc pixels arrive.
  task automatic push_dut(input int k, input int f, input int mode, input int n_acc);
    for (int by = 0; by < H / f; by++) begin
      for (int bx = 0; bx < W / f; bx++) begin
        int   trig;
        int   sum;
        exp_t e;
        trig = (mode == 1) ? (by * f * W + bx * f) : ((by * f + f - 1) * W + bx * f + f - 1);
        if (trig < n_acc) begin
          sum = 0;
          for (int dy = 0; dy < f; dy++)
            for (int dx = 0; dx < f; dx++)
              sum += img[by * f + dy][bx * f + dx];
          e.d   = (mode == 1) ? 8'(img[by * f][bx * f]) : 8'(sum / (f * f));
          e.eol = (bx == W / f - 1);
          e.eof = (bx == W / f - 1) && (by == H / f - 1);
          q[k].push_back(e);
        end
      end
    end
  endtask

  task automatic finish_now();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic send_pixel(input int d, input logic sof, input int vpct, input logic first);
    logic ok;
    int   n;
    while (int'($urandom_range(99)) >= vpct) begin
      avg_if.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    avg_if.in_valid = 1'b1;
    avg_if.in_data  = 8'(d);
    avg_if.in_sof   = sof;
    n = 0;
    do begin
      @(negedge clk);
      ok = avg_if.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL in_accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
      finish_now();
    end
    avg_if.in_valid = 1'b0;
    avg_if.in_sof   = 1'b0;
    if (first) chk("dec_first_latency", 32'(dec_if.out_valid), 32'd1);
  endtask

  task automatic send_frame(input int pat, input int n, input logic sof_first,
                            input int vpct, input int rpct);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++)
        img[yy][xx] = pix(pat, xx, yy);
    push_dut(0, 4, 0, n);
    push_dut(1, 4, 1, n);
    push_dut(2, 16, 0, n);
    rdy_pct = rpct;
    for (int i = 0; i < n; i++)
      send_pixel(img[i / W][i % W], (i == 0) && sof_first, vpct, i == 0);
  endtask

  task automatic drain();
    int n;
    rdy_pct = 100;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 3; k++) chk($sformatf("drain_%0d", k), 32'(q[k].size()), 32'd0);
  endtask

  initial begin
    avg_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      avg_if.out_ready = (int'($urandom_range(99)) < rdy_pct);
    end
  end

  task automatic mon(input int k, input string name, input logic fire, input exp_t act);
    exp_t e;
    if (fire) begin
      if (q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got output 0x%0h expected none", name, act);
      end else begin
        e = q[k].pop_front();
        chk(name, 32'(act), 32'(e));
      end
    end
  endtask

  initial begin
    logic stall_prev;
    exp_t held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_rule", 32'(avg_if.in_ready),
            32'(!avg_if.out_valid || avg_if.out_ready));
        if (stall_prev) begin
          chk("avg_hold_valid", 32'(avg_if.out_valid), 32'd1);
          chk("avg_hold_data", 32'({avg_if.out_data, avg_if.out_eol, avg_if.out_eof}), 32'(held));
        end
        stall_prev = avg_if.out_valid && !avg_if.out_ready;
        held = {avg_if.out_data, avg_if.out_eol, avg_if.out_eof};
        mon(0, "avg_out", avg_if.out_valid && avg_if.out_ready,
            {avg_if.out_data, avg_if.out_eol, avg_if.out_eof});
        mon(1, "dec_out", dec_if.out_valid, {dec_if.out_data, dec_if.out_eol, dec_if.out_eof});
        mon(2, "s4_out", s4_if.out_valid, {s4_if.out_data, s4_if.out_eol, s4_if.out_eof});
      end
    end
  end

  initial begin
    avg_if.in_valid = 1'b0;
    avg_if.in_data  = '0;
    avg_if.in_sof   = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_avg", 32'({avg_if.out_valid, avg_if.out_data, avg_if.out_eol, avg_if.out_eof}), 32'd0);
    chk("reset_dec", 32'({dec_if.out_valid, dec_if.out_data, dec_if.out_eol, dec_if.out_eof}), 32'd0);
    chk("reset_in_ready", 32'(avg_if.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(0, NPIX, 1'b1, 100, 100);
    send_frame(1, NPIX, 1'b1, 100, 100);
    send_frame(2, NPIX, 1'b1, 100, 100);
    send_frame(3, NPIX, 1'b1, 100, 100);
    send_frame(4, NPIX, 1'b1, 60, 70);
    send_frame(1, NPIX, 1'b1, 60, 30);
    send_frame(4, 18 * W + 10, 1'b1, 80, 70);
    send_frame(4, NPIX, 1'b1, 80, 70);
    drain();

    // Reset lands between clock edges, mid-frame; outputs must clear immediately.
    send_frame(4, 10 * W + 5, 1'b1, 80, 70);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_avg", 32'({avg_if.out_valid, avg_if.out_data, avg_if.out_eol, avg_if.out_eof}), 32'd0);
    chk("async_rst_dec", 32'({dec_if.out_valid, dec_if.out_data, dec_if.out_eol, dec_if.out_eof}), 32'd0);
    chk("async_rst_s4", 32'({s4_if.out_valid, s4_if.out_data, s4_if.out_eol, s4_if.out_eof}), 32'd0);
    for (int k = 0; k < 3; k++) q[k].delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send_frame(3, NPIX, 1'b0, 80, 70);
    drain();
    finish_now();
  end
endmodule

// File: doc/box_downscale_stream.md
BOX_DOWNSCALE_STREAM -- requirements
Module: box_downscale_stream

Interface
REQ-001 The block SHALL have parameter DW, default 8, pixel data width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 256, input pixels per line; must be a multiple of 2^S.
REQ-003 The block SHALL have parameter IMG_H, default 256, input lines per frame; must be a multiple of 2^S.
REQ-004 The block SHALL have parameter S, default 2, log2 of the scale factor F=2^S, valid range 1..4.
REQ-005 The block SHALL have parameter MODE, default 0, where 0 is box average and 1 is decimate (top-left pixel of each block).
REQ-006 The block SHALL have port clk, input, 1 bit, clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-008 The block SHALL have port in_valid, input, 1 bit, input pixel valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, block accepts input this cycle.
REQ-010 The block SHALL have port in_data, input, DW bits, input pixel, raster order.
REQ-011 The block SHALL have port in_sof, input, 1 bit, qualified by in_valid; marks the pixel at x=0, y=0 of a frame.
REQ-012 The block SHALL have port out_valid, output, 1 bit, output pixel valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, downstream accepts output.
REQ-014 The block SHALL have port out_data, output, DW bits, scaled pixel.
REQ-015 The block SHALL have port out_eol, output, 1 bit, qualified by out_valid; last pixel of an output line.
REQ-016 The block SHALL have port out_eof, output, 1 bit, qualified by out_valid; last pixel of an output frame.

Function
REQ-017 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-018 in_ready SHALL equal (!out_valid | out_ready), combinationally.
REQ-019 The block SHALL track the position of the next accepted pixel with x in 0..IMG_W-1 and y in 0..IMG_H-1; x wraps to 0 and y increments after x=IMG_W-1; y wraps to 0 after y=IMG_H-1.
REQ-020 For each pixel, xb=x mod F, yb=y mod F, and col=x>>S.
REQ-021 An accepted pixel with in_sof=1 SHALL be processed as x=0, y=0 regardless of counter state. The previous partial frame SHALL be discarded with no output for it.
REQ-022 A horizontal accumulator of width DW+S SHALL load in_data at xb=0 and add in_data otherwise.
REQ-023 The line buffer SHALL have IMG_W/F entries of DW+2S bits each.
REQ-024 At xb=F-1, the line buffer entry [col] SHALL be written with the horizontal sum when yb=0, and with the entry plus the horizontal sum otherwise.
REQ-025 The line buffer SHALL be written in both modes. In MODE=1 its contents are unused.
REQ-026 MODE=0: at xb=F-1 and yb=F-1, out_data SHALL be registered as (entry[col] + hsum) >> 2S. Truncation is used with no rounding, and all arithmetic is full width with no overflow.
REQ-027 MODE=1: at xb=0 and yb=0, out_data SHALL be registered as in_data.
REQ-028 out_valid SHALL rise on the clock edge that accepts the completing pixel, giving 1-cycle latency. It SHALL hold with out_data, out_eol and out_eof stable until the output transfer.
REQ-029 out_eol SHALL be 1 when the output column equals IMG_W/F-1.
REQ-030 out_eof SHALL be 1 when out_eol is 1 and the output row equals IMG_H/F-1.
REQ-031 On a single edge, an output transfer and a new output-producing input SHALL reload the output register with no bubble.
REQ-032 Cycles without an input transfer SHALL leave the counters, accumulator and line buffer unchanged.
REQ-033 Over a full frame the block SHALL emit exactly (IMG_W/F)*(IMG_H/F) outputs.

Reset
REQ-034 While rst_n=0, the block SHALL hold out_valid=0, out_data=0, out_eol=0, out_eof=0, x=0, y=0 and the accumulator at 0.
REQ-035 Line buffer contents need not be reset. They SHALL never affect outputs because yb=0 always overwrites before any read.
REQ-036 After reset deasserts mid-frame, the next accepted pixel SHALL be treated as x=0, y=0 whether or not in_sof is set.

Verification
REQ-037 Defaults, MODE=0, a constant frame of 200 with out_ready=1 -> 4096 outputs all equal to 200; out_eol every 64th output; out_eof on the 4096th output only.
REQ-038 Defaults, MODE=0, pixel = x[7:0] -> each output row is 1.5, 5.5, ... truncated, i.e. 1, 5, 9, ..., 253.
REQ-039 Defaults, MODE=0, all pixels 255 -> every output is 255, proving no accumulator overflow; repeat with S=4, IMG_W=IMG_H=64 -> 16 outputs of 255.
REQ-040 Defaults, MODE=1, pixel = {y[3:0], x[3:0]} -> output (c, r) equals {(4r)[3:0], (4c)[3:0]}, and the first output appears 1 cycle after the first accepted pixel.
REQ-041 Random out_ready at 30% and random in_valid -> output sequence identical to the out_ready=1 run; out_data stable while out_valid=1 and out_ready=0; in_ready=0 exactly in those cycles.
REQ-042 in_sof asserted at input line 130, then a full frame -> no output for the partial frame and exactly 4096 correct outputs follow. Then assert rst_n=0 mid-frame -> all outputs 0 on the same cycle, asynchronously; after release, a clean frame gives correct results.
